mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It sits between the execute stage and the write-back stage. It accepts `es_to_ms_bus` under the valid/allowin handshake and waits for data-SRAM read data on loads. It selects the final result, passes it to write-back, and drives the MEM-side forwarding value and load-pending flag to the hazard unit.

---
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Holds one instruction from EXE, waits for data-SRAM read data on loads,
// selects the final result and hands it to write-back. It also drives the
// MEM-side forwarding value and the load-pending flag for the hazard unit.
//
// Optional feature macro: MS_RDATA_BUF_EN
//   defined   : a HOLD state plus a 32-bit rdata buffer let rvalid be a
//               single-cycle pulse even when write-back is stalled.
//   undefined : no buffer; the SRAM keeps rvalid/rdata up until the
//               ms_to_ws handshake and the state machine stays in IDLE.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where the sender's valid and the receiver's allowin are both high; the
// sender keeps its payload stable while valid is high and allowin is low.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [9:0]                 es_to_ms_addr,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [9:0]                 ms_to_ws_addr,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       data_sram_rvalid,
    output logic [31:0]                es_forward_ms,
    output logic                       ms_valid_tohazard,
    output logic                       ms_load_pending,
    output logic [15:0]                ms_load_wait_cnt,
    output logic                       ms_state_dbg
);

    // IDLE: load waiting for (or passing through) its data.
    // HOLD: load data captured in the buffer, waiting for write-back.
    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_HOLD = 1'b1
    } ms_state_e;

    // Registered state
    logic                       ms_valid_q;
    logic                       ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_d;
    logic [9:0]                 addr_q;
    logic [9:0]                 addr_d;
    ms_state_e                  state_q;
    ms_state_e                  state_d;
    logic [15:0]                wait_cnt_q;
    logic [15:0]                wait_cnt_d;
`ifdef MS_RDATA_BUF_EN
    logic [31:0]                rdata_buf_q;
    logic [31:0]                rdata_buf_d;
`endif

    // Decoded fields of the held EXE payload
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    // Control
    logic        load_data_valid;
    logic        ms_ready_go;
    logic        es_hs;
    logic        ws_hs;
    logic        load_pending;
    logic [31:0] final_result;

    assign res_from_mem = bus_q[70];
    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign alu_result   = bus_q[63:32];
    assign pc           = bus_q[31:0];

    // Readiness, result selection and handshakes for the held instruction
    always_comb begin
        // rvalid only counts for a valid load still waiting in IDLE; any
        // other rvalid is spurious and must not disturb the stage.
        load_data_valid = ms_valid_q && res_from_mem && (state_q == MS_IDLE)
                          && data_sram_rvalid;
`ifdef MS_RDATA_BUF_EN
        ms_ready_go = !res_from_mem || load_data_valid || (state_q == MS_HOLD);
`else
        ms_ready_go = !res_from_mem || load_data_valid;
`endif
        final_result = 32'h0;
        if (!res_from_mem) begin
            final_result = alu_result;
`ifdef MS_RDATA_BUF_EN
        end else if (state_q == MS_HOLD) begin
            final_result = rdata_buf_q;
`endif
        end else if (load_data_valid) begin
            final_result = data_sram_rdata;
        end
        ms_allowin   = !ms_valid_q || (ms_ready_go && ws_allowin);
        es_hs        = es_to_ms_valid && ms_allowin;
        ws_hs        = ms_valid_q && ms_ready_go && ws_allowin;
        load_pending = ms_valid_q && res_from_mem && !ms_ready_go;
    end

    // Next-state for the pipeline register and the load-wait counter
    always_comb begin
        ms_valid_d = ms_valid_q;
        bus_d      = bus_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (es_hs) begin
            bus_d  = es_to_ms_bus;
            addr_d = es_to_ms_addr;
        end
        if (load_pending && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // Next-state for the load-data state machine and its buffer
    always_comb begin
        state_d = state_q;
`ifdef MS_RDATA_BUF_EN
        rdata_buf_d = rdata_buf_q;
        case (state_q)
            MS_IDLE: begin
                // Data arrived but write-back is stalled: keep a copy so
                // the SRAM may drop rvalid after one cycle.
                if (load_data_valid && !ws_allowin) begin
                    state_d     = MS_HOLD;
                    rdata_buf_d = data_sram_rdata;
                end
            end
            MS_HOLD: begin
                // In HOLD the stage is ready, so ws_allowin is the handshake.
                if (ws_hs) begin
                    state_d = MS_IDLE;
                end
            end
            default: state_d = MS_IDLE;
        endcase
`else
        state_d = MS_IDLE;
`endif
    end

    // All stage flops; reset drops any instruction, including a waiting load
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            addr_q      <= '0;
            state_q     <= MS_IDLE;
            wait_cnt_q  <= 16'h0;
`ifdef MS_RDATA_BUF_EN
            rdata_buf_q <= 32'h0;
`endif
        end else begin
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            addr_q      <= addr_d;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
`ifdef MS_RDATA_BUF_EN
            rdata_buf_q <= rdata_buf_d;
`endif
        end
    end

    assign ms_to_ws_valid    = ms_valid_q && ms_ready_go;
    assign ms_to_ws_bus      = {gr_we, dest, final_result, pc};
    assign ms_to_ws_addr     = addr_q;
    assign es_forward_ms     = final_result;
    assign ms_valid_tohazard = ms_valid_q;
    assign ms_load_pending   = load_pending;
    assign ms_load_wait_cnt  = wait_cnt_q;
    assign ms_state_dbg      = (state_q == MS_HOLD);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios with literal expectations followed by a
// randomized run checked every cycle against a queue-based model of the
// MEM stage (one in-flight slot, load result filled in when data arrives).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ws_allowin = 1'b0;
    logic        ms_allowin;
    logic        es_to_ms_valid = 1'b0;
    logic [70:0] es_to_ms_bus = '0;
    logic [9:0]  es_to_ms_addr = '0;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [9:0]  ms_to_ws_addr;
    logic [31:0] data_sram_rdata = '0;
    logic        data_sram_rvalid = 1'b0;
    logic [31:0] es_forward_ms;
    logic        ms_valid_tohazard;
    logic        ms_load_pending;
    logic [15:0] ms_load_wait_cnt;
    logic        ms_state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: expected {addr, ws bus} of the instruction held in MEM
    logic [79:0] exp_q[$];
    logic        slot_load = 1'b0;
    logic        slot_got  = 1'b0;
    logic [15:0] cnt_m     = 16'h0;
    logic        prev_hold = 1'b0;
    logic [69:0] prev_bus  = '0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_to_ms_addr     (es_to_ms_addr),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ws_addr     (ms_to_ws_addr),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_rvalid  (data_sram_rvalid),
        .es_forward_ms     (es_forward_ms),
        .ms_valid_tohazard (ms_valid_tohazard),
        .ms_load_pending   (ms_load_pending),
        .ms_load_wait_cnt  (ms_load_wait_cnt),
        .ms_state_dbg      (ms_state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [70:0] mk_bus(input logic ld, input logic we, input logic [4:0] dst,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {ld, we, dst, alu, pc};
    endfunction

    // Compare process: settled values are sampled 2 time units after the
    // falling edge, when this cycle's inputs are stable.
    always @(negedge clk) begin
        logic        occ;
        logic        ready;
        logic        pend;
        logic        exp_allow;
        logic        data_now;
        logic [79:0] t;
        #2;
        if (!resetn) begin
            exp_q.delete();
            slot_load = 1'b0;
            slot_got  = 1'b0;
            cnt_m     = 16'h0;
            prev_hold = 1'b0;
            chk("rst_ws_valid", ms_to_ws_valid, 0);
            chk("rst_allowin", ms_allowin, 1);
            chk("rst_wait_cnt", ms_load_wait_cnt, 0);
            chk("rst_forward", es_forward_ms, 0);
            chk("rst_pending", ms_load_pending, 0);
        end else begin
            occ      = (exp_q.size() != 0);
            data_now = occ && slot_load && !slot_got && data_sram_rvalid;
            if (data_now) begin
                t = exp_q[0];
                t[63:32] = data_sram_rdata;
                exp_q[0] = t;
            end
            ready     = occ && (!slot_load || slot_got || data_sram_rvalid);
            pend      = occ && slot_load && !ready;
            exp_allow = !occ || (ready && ws_allowin);
            chk("m_ws_valid", ms_to_ws_valid, ready);
            chk("m_allowin", ms_allowin, exp_allow);
            chk("m_pending", ms_load_pending, pend);
            chk("m_valid_hz", ms_valid_tohazard, occ);
            chk("m_wait_cnt", ms_load_wait_cnt, cnt_m);
            if (ready) begin
                chk("m_payload", {ms_to_ws_addr, ms_to_ws_bus}, exp_q[0]);
                chk("m_forward", es_forward_ms, exp_q[0][63:32]);
            end
            if (prev_hold) chk("m_stable", ms_to_ws_bus, prev_bus);
            prev_hold = ready && !ws_allowin;
            prev_bus  = ms_to_ws_bus;
            if (pend && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`ifdef MS_RDATA_BUF_EN
            if (data_now) slot_got = 1'b1;
`endif
            if (ready && ws_allowin) begin
                void'(exp_q.pop_front());
                slot_got = 1'b0;
            end
            if (es_to_ms_valid && exp_allow) begin
                exp_q.push_back({es_to_ms_addr, es_to_ms_bus[69:0]});
                slot_load = es_to_ms_bus[70];
                slot_got  = 1'b0;
            end
        end
    end

    // Stimulus and directed checks
    initial begin
        logic        busy;
        logic        busy_load;
        logic        delivered;
        logic        drain;
        logic        ws_hs;
        logic        exe_hs;
        int          age;
        int          delay;
        logic [31:0] held;
        busy = 0; busy_load = 0; delivered = 0; age = 0; delay = 0; held = '0;

        // Reset values
        @(negedge clk); #1;
        chk("reset_allowin", ms_allowin, 1);
        chk("reset_ws_valid", ms_to_ws_valid, 0);
        chk("reset_forward", es_forward_ms, 0);
        chk("reset_cnt", ms_load_wait_cnt, 0);
        chk("reset_state", ms_state_dbg, 0);
        @(negedge clk); resetn = 1'b1;

        // ADD alu=5
        @(negedge clk);
        es_to_ms_valid = 1; ws_allowin = 1;
        es_to_ms_bus = mk_bus(0, 1, 5'd3, 32'h5, 32'h100); es_to_ms_addr = 10'h021;
        @(negedge clk); es_to_ms_valid = 0; #1;
        chk("add_valid", ms_to_ws_valid, 1);
        chk("add_result", ms_to_ws_bus[63:32], 32'h5);
        chk("add_pending", ms_load_pending, 0);

        // LW with data three cycles late
        @(negedge clk);
        es_to_ms_valid = 1; es_to_ms_bus = mk_bus(1, 1, 5'd4, 32'h200, 32'h104);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); es_to_ms_valid = 0; #1;
            chk("lw_pending", ms_load_pending, 1);
        end
        @(negedge clk); data_sram_rvalid = 1; data_sram_rdata = 32'hDEAD_BEEF; #1;
        chk("lw_valid", ms_to_ws_valid, 1);
        chk("lw_forward", es_forward_ms, 32'hDEAD_BEEF);
        chk("lw_pending_end", ms_load_pending, 0);
        @(negedge clk); data_sram_rvalid = 0; #1;
        chk("lw_cnt", ms_load_wait_cnt, 3);
        chk("lw_gone", ms_to_ws_valid, 0);

`ifdef MS_RDATA_BUF_EN
        // LW with single-cycle rvalid while write-back is stalled
        @(negedge clk);
        es_to_ms_valid = 1; ws_allowin = 0; es_to_ms_bus = mk_bus(1, 1, 5'd5, 32'h300, 32'h108);
        @(negedge clk); es_to_ms_valid = 0; data_sram_rvalid = 1; data_sram_rdata = 32'h1234_5678; #1;
        chk("hold_in_allowin", ms_allowin, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); data_sram_rvalid = 0; data_sram_rdata = 32'h0BAD_0BAD; #1;
            chk("hold_state", ms_state_dbg, 1);
            chk("hold_forward", es_forward_ms, 32'h1234_5678);
            chk("hold_allowin", ms_allowin, 0);
        end
        @(negedge clk); ws_allowin = 1; #1;
        chk("hold_release_allowin", ms_allowin, 1);
        chk("hold_release_result", ms_to_ws_bus[63:32], 32'h1234_5678);
        @(negedge clk); #1;
        chk("hold_done_state", ms_state_dbg, 0);
        chk("hold_done_valid", ms_to_ws_valid, 0);
`endif

        // Spurious rvalid while an ADD sits in MEM
        @(negedge clk);
        es_to_ms_valid = 1; ws_allowin = 0; es_to_ms_bus = mk_bus(0, 1, 5'd6, 32'h7, 32'h10C);
        @(negedge clk); es_to_ms_valid = 0; data_sram_rvalid = 1; data_sram_rdata = 32'hFFFF_FFFF; #1;
        chk("spur_forward", es_forward_ms, 32'h7);
        @(negedge clk); data_sram_rvalid = 0; #1;
        chk("spur_forward2", es_forward_ms, 32'h7);
        chk("spur_valid", ms_to_ws_valid, 1);
        @(negedge clk); ws_allowin = 1; #1;
        chk("spur_result", ms_to_ws_bus[63:32], 32'h7);

        // Reset during a load wait, late rvalid afterwards
        @(negedge clk);
        es_to_ms_valid = 1; es_to_ms_bus = mk_bus(1, 1, 5'd7, 32'h400, 32'h110);
        @(negedge clk); es_to_ms_valid = 0; #1;
        chk("rl_pending", ms_load_pending, 1);
        @(negedge clk);
        @(negedge clk); resetn = 0; #1;
        chk("rl_valid", ms_valid_tohazard, 0);
        chk("rl_cnt", ms_load_wait_cnt, 0);
        @(negedge clk); resetn = 1;
        @(negedge clk);
        @(negedge clk); data_sram_rvalid = 1; data_sram_rdata = 32'hA5A5_A5A5; #1;
        chk("rl_late_valid", ms_valid_tohazard, 0);
        chk("rl_late_ws_valid", ms_to_ws_valid, 0);
        chk("rl_late_cnt", ms_load_wait_cnt, 0);
        chk("rl_late_forward", es_forward_ms, 0);
        @(negedge clk); data_sram_rvalid = 0;

        // Back-to-back ADD 1, ADD 2
        @(negedge clk);
        es_to_ms_valid = 1; ws_allowin = 1; es_to_ms_bus = mk_bus(0, 1, 5'd8, 32'h1, 32'h114);
        @(negedge clk); es_to_ms_bus = mk_bus(0, 1, 5'd9, 32'h2, 32'h118); #1;
        chk("b2b_valid1", ms_to_ws_valid, 1);
        chk("b2b_fwd1", es_forward_ms, 32'h1);
        chk("b2b_allowin", ms_allowin, 1);
        @(negedge clk); es_to_ms_valid = 0; #1;
        chk("b2b_valid2", ms_to_ws_valid, 1);
        chk("b2b_fwd2", es_forward_ms, 32'h2);
        @(negedge clk); #1;
        chk("b2b_empty", ms_to_ws_valid, 0);

        // Randomized traffic; final cycles drain with write-back open
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            drain = (c >= 1460);
            es_to_ms_valid = !drain && ($urandom_range(0, 3) != 0);
            es_to_ms_bus = mk_bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  5'($urandom_range(0, 31)), $urandom, $urandom);
            es_to_ms_addr = 10'($urandom_range(0, 1023));
            ws_allowin = drain || ($urandom_range(0, 3) != 0);
            if (busy && busy_load && !delivered && age >= delay) begin
                data_sram_rvalid = 1; held = $urandom; data_sram_rdata = held;
            end else if (busy && busy_load && delivered) begin
`ifdef MS_RDATA_BUF_EN
                data_sram_rvalid = ($urandom_range(0, 2) == 0); data_sram_rdata = $urandom;
`else
                data_sram_rvalid = 1; data_sram_rdata = held;
`endif
            end else if (busy && busy_load) begin
                data_sram_rvalid = 0; data_sram_rdata = $urandom;
            end else begin
                data_sram_rvalid = ($urandom_range(0, 4) == 0); data_sram_rdata = $urandom;
            end
            #1;
            exe_hs = es_to_ms_valid && ms_allowin;
            ws_hs  = ms_to_ws_valid && ws_allowin;
            if (busy && busy_load && data_sram_rvalid) delivered = 1;
            if (ws_hs) busy = 0;
            if (exe_hs) begin
                busy = 1; busy_load = es_to_ms_bus[70];
                age = 0; delay = $urandom_range(0, 4); delivered = 0;
            end else if (busy) begin
                age++;
            end
        end
        @(negedge clk); es_to_ms_valid = 0; data_sram_rvalid = 0; #3;
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
